div32: RTL and testbench

Iterative 32-bit integer divider for the myCPU execute stage, serving DIV/DIVU. It is the inverse counterpart of the shift-add multiplier. Restoring division retires one quotient bit per clock. Results are held in registers and are read into HI/LO after `done`. Operands are latched on a start handshake, so the pipeline may change its operand buses while the divider is busy.

---
 rtl/div32.sv | 175 +++++++++++++++++
 tb/tb_div32.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div32.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, fixed 34-cycle latency.
// Operands are latched on start; q/r are registered and hold until the next result.
module div32 #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sign,
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    output logic [DATA_SIZE-1:0] q,
    output logic [DATA_SIZE-1:0] r,
    output logic                 busy,
    output logic                 done
);

    localparam int                   CNT_W    = $clog2(DATA_SIZE);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_SIZE - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_SIZE-1:0] ZERO_W   = {DATA_SIZE{1'b0}};
    localparam logic [DATA_SIZE-1:0] ONES_W   = {DATA_SIZE{1'b1}};
    localparam logic [DATA_SIZE-1:0] ONE_W    = {{(DATA_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    function automatic logic [DATA_SIZE-1:0] neg_w(input logic [DATA_SIZE-1:0] x);
        return (~x) + ONE_W;
    endfunction

    // The most negative value maps onto itself, which reads correctly as an unsigned magnitude.
    function automatic logic [DATA_SIZE-1:0] abs_w(input logic [DATA_SIZE-1:0] x);
        return x[DATA_SIZE-1] ? neg_w(x) : x;
    endfunction

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] a_q, a_d;
    logic [DATA_SIZE-1:0] b_q, b_d;
    logic                 sign_q, sign_d;
    logic [DATA_SIZE-1:0] divisor_q, divisor_d;
    logic [DATA_SIZE-1:0] dshift_q, dshift_d;
    logic [DATA_SIZE-1:0] rem_q, rem_d;
    logic [DATA_SIZE-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [DATA_SIZE-1:0] q_q, q_d;
    logic [DATA_SIZE-1:0] r_q, r_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DATA_SIZE:0]   trial_s;

    // A kept remainder is always below the divisor, so its upper (33rd) bit is never needed.
    assign trial_s = {rem_q, dshift_q[DATA_SIZE-1]} - {1'b0, divisor_q};

    // Next-state and datapath update for the IDLE/PREP/ITER/FIX sequence.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        divisor_d = divisor_q;
        dshift_d  = dshift_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        q_d       = q_q;
        r_d       = r_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sign_d  = sign;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                divisor_d = sign_q ? abs_w(b_q) : b_q;
                dshift_d  = sign_q ? abs_w(a_q) : a_q;
                qneg_d    = sign_q & (a_q[DATA_SIZE-1] ^ b_q[DATA_SIZE-1]);
                rneg_d    = sign_q & a_q[DATA_SIZE-1];
                rem_d     = ZERO_W;
                quo_d     = ZERO_W;
                cnt_d     = {CNT_W{1'b0}};
                state_d   = S_ITER;
            end
            S_ITER: begin
                if (!trial_s[DATA_SIZE]) begin
                    rem_d = trial_s[DATA_SIZE-1:0];
                end else begin
                    rem_d = {rem_q[DATA_SIZE-2:0], dshift_q[DATA_SIZE-1]};
                end
                quo_d    = {quo_q[DATA_SIZE-2:0], ~trial_s[DATA_SIZE]};
                dshift_d = {dshift_q[DATA_SIZE-2:0], 1'b0};
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_FIX: begin
                if (b_q == ZERO_W) begin
                    q_d = ONES_W;
                    r_d = a_q;
                end else begin
                    q_d = qneg_q ? neg_w(quo_q) : quo_q;
                    r_d = rneg_q ? neg_w(rem_q) : rem_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            a_q       <= ZERO_W;
            b_q       <= ZERO_W;
            sign_q    <= 1'b0;
            divisor_q <= ZERO_W;
            dshift_q  <= ZERO_W;
            rem_q     <= ZERO_W;
            quo_q     <= ZERO_W;
            cnt_q     <= {CNT_W{1'b0}};
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            q_q       <= ZERO_W;
            r_q       <= ZERO_W;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            divisor_q <= divisor_d;
            dshift_q  <= dshift_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            q_q       <= q_d;
            r_q       <= r_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_div32.sv
// Self-checking bench for div32: directed cases plus randomized operands against an arithmetic model.
module tb_div32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div32 #(.DATA_SIZE(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division (truncating), with the divide-by-zero rule applied first.
    task automatic ref_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                           output logic [31:0] eq, output logic [31:0] er);
        longint xi, yi, qi, ri;
        if (y == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = x;
        end else if (s) begin
            xi = longint'($signed(x));
            yi = longint'($signed(y));
            qi = xi / yi;
            ri = xi % yi;
            eq = qi[31:0];
            er = ri[31:0];
        end else begin
            eq = x / y;
            er = x % y;
        end
    endtask

    // Present a request; returns 1 time unit after the accepting edge (E0) with operands scrambled.
    task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s);
        start = 1'b1;
        a     = x;
        b     = y;
        sign  = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sign  = 1'($urandom);
        check_eq("busy_after_e0", 64'(busy), 64'd1);
        check_eq("done_low_after_e0", 64'(done), 64'd0);
    endtask

    // Walk E1..E34 checking the busy window, then the done pulse and result at E34.
    task automatic finish_div(input string tag, input logic [31:0] eq, input logic [31:0] er,
                              input int inj, input logic [31:0] ia, input logic [31:0] ib);
        int bad = 0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            if (k == inj) begin
                start = 1'b1;
                a     = ia;
                b     = ib;
                sign  = 1'b0;
            end else if (k == inj + 1) begin
                start = 1'b0;
            end
            if (k < 34 && (busy !== 1'b1 || done !== 1'b0)) bad++;
        end
        check_eq($sformatf("%s_busy_window", tag), 64'(bad), 64'd0);
        check_eq($sformatf("%s_done", tag), 64'(done), 64'd1);
        check_eq($sformatf("%s_busy_end", tag), 64'(busy), 64'd0);
        check_eq($sformatf("%s_q", tag), 64'(q), 64'(eq));
        check_eq($sformatf("%s_r", tag), 64'(r), 64'(er));
    endtask

    task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic s, input logic [31:0] eq, input logic [31:0] er);
        launch(x, y, s);
        finish_div(tag, eq, er, 0, 32'd0, 32'd0);
    endtask

    logic [31:0] rx, ry, rq, rr;
    logic        rs;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        sign  = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        #12;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_q", 64'(q), 64'd0);
        check_eq("rst_r", 64'(r), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_one("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        @(posedge clk);
        #1;
        check_eq("done_single_cycle", 64'(done), 64'd0);

        run_one("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_one("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
        run_one("s_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF);
        run_one("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        run_one("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
        run_one("u_5_big", 32'd5, 32'h8000_0000, 1'b0, 32'd0, 32'd5);
        run_one("u_div0", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
        run_one("s_div0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);

        // Second request while busy must be dropped; the next one arrives in the done cycle.
        launch(32'd20, 32'd3, 1'b0);
        finish_div("ignored_start", 32'd6, 32'd2, 10, 32'd50, 32'd5);
        launch(32'd50, 32'd5, 1'b0);
        finish_div("back_to_back", 32'd10, 32'd0, 0, 32'd0, 32'd0);

        // Asynchronous reset in the middle of the iterations.
        launch(32'd1000, 32'd3, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        check_eq("midrst_q", 64'(q), 64'd0);
        check_eq("midrst_r", 64'(r), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("postrst_idle", 64'(busy), 64'd0);
        run_one("after_rst", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);

        for (int i = 0; i < 30; i++) begin
            rx = $urandom;
            if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = $urandom_range(1, 15);
                3:       ry = 32'h8000_0000;
                default: ry = $urandom;
            endcase
            rs = 1'($urandom);
            ref_div(rx, ry, rs, rq, rr);
            run_one($sformatf("rand%0d", i), rx, ry, rs, rq, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
